// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: funct3 width codes, IO select default, FSM encodings and load helpers
package mem_arbiter_pkg;
    localparam logic [1:0] F3_BYTE    = 2'b00;
    localparam logic [1:0] F3_HALF    = 2'b01;
    localparam logic [1:0] IO_SEL_DEF = 2'b11;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD      = 2'd1;
    localparam logic [1:0] ST_WR      = 2'd2;
    function automatic logic [2:0] byte_cnt(input logic [2:0] f3);
        return f3[1:0] == F3_BYTE ? 3'd1 : f3[1:0] == F3_HALF ? 3'd2 : 3'd4;
    endfunction
    function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] f3);
        return f3[1:0] == F3_BYTE ? {{24{~f3[2] & d[7]}}, d[7:0]} :
               f3[1:0] == F3_HALF ? {{16{~f3[2] & d[15]}}, d[15:0]} : d;
    endfunction
endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// mem_arbiter_rr_picker: first requesting channel at or after ptr (modulo N_CH), one-hot and index
module mem_arbiter_rr_picker #(
    parameter int N_CH = 2,
    parameter int IW   = 1
) (
    input  logic [N_CH-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [N_CH-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N_CH]) begin
                gnt = '0;
                gnt[(int'(ptr) + i) % N_CH] = 1'b1;
                idx = IW'((int'(ptr) + i) % N_CH);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: N_CH-channel arbiter onto the byte-serial memory/IO bus; rst_in is async active-low.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int              N_CH       = 2,
    parameter logic [N_CH-1:0] FLUSH_MASK = {N_CH{1'b1}},
    parameter logic [1:0]      IO_SEL     = IO_SEL_DEF
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic [N_CH-1:0]      req_valid,
    input  logic [N_CH-1:0]      req_we,
    input  logic [3*N_CH-1:0]    req_width,
    input  logic [32*N_CH-1:0]   req_addr,
    input  logic [32*N_CH-1:0]   req_wdata,
    output logic [N_CH-1:0]      req_ready,
    output logic [N_CH-1:0]      resp_valid,
    output logic [31:0]          resp_rdata,
    input  logic                 clear_all,
    input  logic                 halt_in,
    input  logic                 io_buffer_full,
    input  logic [7:0]           mem_din,
    output logic [7:0]           mem_dout,
    output logic [31:0]          mem_a,
    output logic                 mem_wr
);
    localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
    logic [1:0]      state;
    logic [IW-1:0]   ch, ptr, idx;
    logic [31:0]     addr, wdata, rbuf, nbuf, cur_a;
    logic [2:0]      f3, cnt, nbytes;
    logic [N_CH-1:0] elig, gnt;
    logic            any, busy, io_stall, abort, prev_rdy;
    logic [7:0]      din_q, rbyte;
    logic [1:0]      lane;

    assign nbytes   = byte_cnt(f3);
    assign cur_a    = addr + 32'(cnt);
    assign busy     = state != ST_IDLE && cnt < nbytes;
    assign io_stall = state == ST_WR && busy && cur_a[17:16] == IO_SEL && io_buffer_full;
    assign abort    = state == ST_RD && clear_all && FLUSH_MASK[ch];
    assign elig     = halt_in ? '0 : req_valid & ~(clear_all ? FLUSH_MASK : '0);
    assign mem_a    = busy ? cur_a : '0;
    assign mem_wr   = rdy_in && state == ST_WR && busy && !io_stall;
    assign mem_dout = state == ST_WR && busy ? wdata[{cnt[1:0], 3'b000} +: 8] : '0;
    // after a freeze mem_din shows the held address, so use the byte parked on the first frozen edge
    assign rbyte    = prev_rdy ? mem_din : din_q;
    assign lane     = 2'(cnt - 3'd1);

    always_comb begin
        nbuf = rbuf;
        nbuf[{lane, 3'b000} +: 8] = rbyte;
    end

    mem_arbiter_rr_picker #(.N_CH(N_CH), .IW(IW)) u_pick (
        .req (elig),
        .ptr (ptr),
        .gnt (gnt),
        .idx (idx),
        .any (any)
    );

`ifdef ARB_FIXED_PRIO_EN
    assign ptr = '0;
`else
    always_ff @(posedge clk_in or negedge rst_in)
        if (!rst_in)
            ptr <= '0;
        else if (rdy_in && state == ST_IDLE && any)
            ptr <= idx == IW'(N_CH - 1) ? '0 : idx + 1'b1;
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            prev_rdy <= 1'b1;
            din_q    <= '0;
        end else begin
            prev_rdy <= rdy_in;
            if (!rdy_in && prev_rdy)
                din_q <= mem_din;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state      <= ST_IDLE;
            ch         <= '0;
            addr       <= '0;
            wdata      <= '0;
            f3         <= '0;
            cnt        <= '0;
            rbuf       <= '0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_rdata <= '0;
        end else if (rdy_in) begin
            req_ready  <= '0;
            resp_valid <= '0;
            if (state == ST_IDLE) begin
                if (any) begin
                    state     <= req_we[idx] ? ST_WR : ST_RD;
                    ch        <= idx;
                    addr      <= req_addr[32*idx +: 32];
                    wdata     <= req_wdata[32*idx +: 32];
                    f3        <= req_width[3*idx +: 3];
                    cnt       <= '0;
                    req_ready <= gnt;
                end
            end else if (abort) begin
                state <= ST_IDLE;
            end else if (cnt == nbytes) begin
                state          <= ST_IDLE;
                resp_valid[ch] <= 1'b1;
                if (state == ST_RD)
                    resp_rdata <= extend(nbuf, f3);
            end else if (!io_stall) begin
                cnt <= cnt + 3'd1;
            end
            if (state == ST_RD && cnt != '0)
                rbuf <= nbuf;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table plus hand sequences for the mem_arbiter corner cases
module tb_mem_arbiter;
    localparam int N  = 2;
    localparam int NV = 13;

    typedef struct {
        int          ch;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, rdy, clear_all, halt, io_full, mem_wr;
    logic [N-1:0] req_valid, req_we, req_ready, resp_valid;
    logic [3*N-1:0] req_width;
    logic [32*N-1:0] req_addr, req_wdata;
    logic [31:0] resp_rdata, mem_a;
    logic [7:0] mem_din, mem_dout, io_last;
    logic [7:0] mem [0:4095];
    int io_cnt = 0;
    int total = 0, passed = 0;
    vec_t v [NV];

    mem_arbiter dut (
        .clk_in(clk), .rst_in(rst_n), .rdy_in(rdy),
        .req_valid(req_valid), .req_we(req_we), .req_width(req_width),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .clear_all(clear_all),
        .halt_in(halt), .io_buffer_full(io_full), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always @(posedge clk) begin
        if (mem_wr) begin
            if (mem_a[17:16] == 2'b11) begin
                io_cnt++;
                io_last = mem_dout;
            end else begin
                mem[mem_a[11:0]] = mem_dout;
            end
        end
        mem_din <= mem[mem_a[11:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid[ch] = 1'b1;
        req_we[ch] = we;
        req_width[3*ch +: 3] = f3;
        req_addr[32*ch +: 32] = a;
        req_wdata[32*ch +: 32] = d;
    endtask

    task automatic wait_resp(input int ch, input int start, output int lat);
        lat = 0;
        for (int n = start; n <= 30; n++) begin
            step();
            if (resp_valid[ch]) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int b, lat, ng;
        int gch [4];
        int gn [4];
        logic ok, seen;
        v[0]  = '{1, 1'b0, 3'b010, 32'h100,      32'h0,        32'h44332211, 5};
        v[1]  = '{0, 1'b0, 3'b000, 32'h10,       32'h0,        32'hFFFFFF80, 2};
        v[2]  = '{0, 1'b0, 3'b100, 32'h10,       32'h0,        32'h00000080, 2};
        v[3]  = '{0, 1'b0, 3'b001, 32'h20,       32'h0,        32'hFFFFFF7F, 3};
        v[4]  = '{1, 1'b0, 3'b101, 32'h20,       32'h0,        32'h0000FF7F, 3};
        v[5]  = '{0, 1'b0, 3'b111, 32'h100,      32'h0,        32'h44332211, 5};
        v[6]  = '{1, 1'b1, 3'b010, 32'h40,       32'hDEADBEEF, 32'h0,        5};
        v[7]  = '{0, 1'b0, 3'b010, 32'h40,       32'h0,        32'hDEADBEEF, 5};
        v[8]  = '{0, 1'b1, 3'b001, 32'h50,       32'h1234ABCD, 32'h0,        3};
        v[9]  = '{1, 1'b0, 3'b001, 32'h50,       32'h0,        32'hFFFFABCD, 3};
        v[10] = '{0, 1'b0, 3'b010, 32'hFFFFFFFF, 32'h0,        32'hD4C3B2A1, 5};
        v[11] = '{1, 1'b1, 3'b000, 32'h58,       32'h000000C5, 32'h0,        2};
        v[12] = '{0, 1'b0, 3'b000, 32'h58,       32'h0,        32'hFFFFFFC5, 2};
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
        mem[12'h010] = 8'h80; mem[12'h020] = 8'h7F; mem[12'h021] = 8'hFF;
        mem[12'hFFF] = 8'hA1; mem[12'h000] = 8'hB2; mem[12'h001] = 8'hC3; mem[12'h002] = 8'hD4;
        rst_n = 1'b0; rdy = 1'b1; clear_all = 1'b0; halt = 1'b0; io_full = 1'b0;
        req_valid = '0; req_we = '0; req_width = '0; req_addr = '0; req_wdata = '0;
        repeat (3) step();
        chk("rst_ctl", 32'({req_ready, resp_valid, mem_wr}), 32'h0);
        chk("rst_a", mem_a, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_dout", 32'(mem_dout), 32'h0);
        rst_n = 1'b1;
        step();

        for (int r = 0; r < NV; r++) begin
            b = v[r].f3[1:0] == 2'b00 ? 1 : v[r].f3[1:0] == 2'b01 ? 2 : 4;
            drive(v[r].ch, v[r].we, v[r].f3, v[r].addr, v[r].wdata);
            step();
            chk($sformatf("ready_%0d", r), 32'(req_ready), 32'(1 << v[r].ch));
            ok = mem_a == v[r].addr;
            req_valid = '0;
            lat = 0;
            for (int n = 1; n <= 20; n++) begin
                step();
                if (n < b && mem_a != v[r].addr + 32'(n)) ok = 1'b0;
                if (resp_valid[v[r].ch]) begin
                    lat = n;
                    break;
                end
            end
            chk($sformatf("addr_seq_%0d", r), 32'(ok), 32'h1);
            chk($sformatf("lat_%0d", r), lat, v[r].lat);
            if (!v[r].we) chk($sformatf("rdata_%0d", r), resp_rdata, v[r].exp);
        end

        drive(1, 1'b1, 3'b000, 32'h30000, 32'h41);
        io_full = 1'b1;
        step();
        req_valid = '0;
        chk("io_stall0", 32'(mem_wr), 32'h0);
        step();
        chk("io_stall1", 32'(mem_wr), 32'h0);
        step();
        chk("io_stall2", 32'(mem_wr), 32'h0);
        step();
        io_full = 1'b0;
        #1;
        chk("io_resume_wr", 32'(mem_wr), 32'h1);
        chk("io_resume_dout", 32'(mem_dout), 32'h41);
        chk("io_resume_a", mem_a, 32'h30000);
        wait_resp(1, 4, lat);
        chk("io_lat", lat, 5);
        chk("io_cnt", io_cnt, 1);
        chk("io_data", 32'(io_last), 32'h41);

        drive(0, 1'b0, 3'b010, 32'h100, 32'h0);
        step();
        req_valid = '0;
        step();
        chk("abort_a1", mem_a, 32'h101);
        clear_all = 1'b1;
        step();
        clear_all = 1'b0;
        chk("abort_idle", mem_a, 32'h0);
        seen = 1'b0;
        repeat (6) begin
            step();
            if (resp_valid[0]) seen = 1'b1;
        end
        chk("abort_no_resp", 32'(seen), 32'h0);

        drive(1, 1'b1, 3'b010, 32'h60, 32'h01020304);
        step();
        req_valid = '0;
        clear_all = 1'b1;
        wait_resp(1, 1, lat);
        clear_all = 1'b0;
        chk("clr_wr_lat", lat, 5);
        chk("clr_wr_mem", {mem[12'h063], mem[12'h062], mem[12'h061], mem[12'h060]}, 32'h01020304);

        drive(0, 1'b0, 3'b010, 32'h100, 32'h0);
        step();
        req_valid = '0;
        step();
        chk("rdy_a1", mem_a, 32'h101);
        rdy = 1'b0;
        step();
        chk("rdy_frozen_a", mem_a, 32'h101);
        chk("rdy_frozen_wr", 32'(mem_wr), 32'h0);
        step();
        rdy = 1'b1;
        chk("rdy_resume_a", mem_a, 32'h101);
        wait_resp(0, 4, lat);
        chk("rdy_lat", lat, 7);
        chk("rdy_rdata", resp_rdata, 32'h44332211);

        halt = 1'b1;
        drive(0, 1'b0, 3'b000, 32'h10, 32'h0);
        seen = 1'b0;
        repeat (3) begin
            step();
            if (req_ready != '0) seen = 1'b1;
        end
        chk("halt_no_grant", 32'(seen), 32'h0);
        halt = 1'b0;
        step();
        chk("halt_release", 32'(req_ready), 32'h1);
        req_valid = '0;
        wait_resp(0, 1, lat);
        chk("halt_lat", lat, 2);
        chk("halt_rdata", resp_rdata, 32'hFFFFFF80);

        drive(1, 1'b1, 3'b010, 32'h70, 32'hA5A5A5A5);
        step();
        req_valid = '0;
        step();
        chk("rstw_pre_wr", 32'(mem_wr), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_bus", 32'({mem_wr, mem_dout}), 32'h0);
        chk("rstw_a", mem_a, 32'h0);
        chk("rstw_pulses", 32'({req_ready, resp_valid}), 32'h0);
        step();
        rst_n = 1'b1;
        step();

        drive(0, 1'b0, 3'b000, 32'h10, 32'h0);
        drive(1, 1'b0, 3'b000, 32'h10, 32'h0);
        ng = 0;
        for (int n = 1; n <= 40 && ng < 4; n++) begin
            step();
            if (req_ready != '0) begin
                gch[ng] = req_ready[1] ? 1 : 0;
                gn[ng] = n;
                ng++;
            end
        end
        req_valid = '0;
        chk("rr_count", ng, 4);
        for (int i = 0; i < ng; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            chk($sformatf("grant_%0d", i), gch[i], 0);
`else
            chk($sformatf("grant_%0d", i), gch[i], i % 2);
`endif
            if (i > 0) chk($sformatf("gap_%0d", i), gn[i] - gn[i-1], 3);
        end
        repeat (6) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised successor to the two-client memory controller: N_CH requesters (default ch0 = icache, ch1 = lsb) share the single byte-serial 8-bit memory/IO bus.
- Transfers are 1/2/4 bytes, little-endian, with load sign/zero extension, IO-write back-pressure, selective flush abort and halt drain.
- Sits between the icache/lsb (and future clients such as a data cache or prefetcher) and the cpu top-level mem_* pins.

Parameters:
- N_CH, 2, number of requesting channels (1..8).
- FLUSH_MASK, {N_CH{1'b1}}, bit i set: reads of channel i are aborted by clear_all.
- IO_SEL, 2'b11, value of addr[17:16] that marks an IO access.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-low.
- rdy_in  in  1  global enable; low freezes all state.
- req_valid  in  N_CH  request pending, held until req_ready.
- req_we  in  N_CH  1 = write.
- req_width  in  3*N_CH  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  32*N_CH  byte address.
- req_wdata  in  32*N_CH  store data, low bytes used.
- req_ready  out  N_CH  one-cycle grant pulse.
- resp_valid  out  N_CH  one-cycle completion pulse (read data or write ack).
- resp_rdata  out  32  extended load data, valid with resp_valid.
- clear_all  in  1  pipeline flush.
- halt_in  in  1  stop granting after the current transfer.
- io_buffer_full  in  1  UART full.
- mem_din  in  8  memory read byte, valid one cycle after its address.
- mem_dout  out  8  write byte.
- mem_a  out  32  address.
- mem_wr  out  1  1 = write.

Behaviour:
- Reset (rst_in low, async): state IDLE, rr_ptr 0, all outputs 0.
- rdy_in low: hold all registers; mem_wr forced 0.
- States: IDLE, RD, WR.
- IDLE:
  - Pick the first valid channel searching from rr_ptr upward, modulo N_CH.
  - On grant: latch channel, addr, width, wdata; byte count B = 1/2/4; go to RD/WR.
  - req_ready[i] is high in the first bus cycle after the grant edge.
  - rr_ptr <= granted + 1 mod N_CH.
- RD:
  - mem_a = addr + k for k = 0..B-1 on consecutive cycles; mem_wr = 0.
  - Byte k is captured from mem_din one cycle later into byte lane k.
  - resp_valid and resp_rdata rise B+1 cycles after the grant edge.
  - Then return to IDLE; the next grant may occur in the resp cycle.
- WR:
  - Drive mem_a = addr + k, mem_dout = wdata byte k, mem_wr = 1, one byte per cycle.
  - resp_valid is asserted the cycle after the last byte; latency is B+1 when not stalled.
- IO write (addr[17:16] == IO_SEL) while io_buffer_full = 1: hold the current byte with mem_wr = 0, then resume. The stall adds cycles.
- Extension:
  - funct3[2] = 0: sign-extend from bit 8B-1.
  - funct3[2] = 1: zero-extend.
  - Widths 011, 110, 111 are treated as 010.
- clear_all:
  - RD for a channel in FLUSH_MASK: return to IDLE next edge, no resp_valid, rr_ptr unchanged.
  - WR: never aborted.
  - IDLE: masked channels are not granted that cycle.
- halt_in: the current transfer completes; no new grants while high.
- Simultaneous completion and new request: the resp cycle is an IDLE cycle, so arbitration proceeds normally and turnaround is 1 cycle.
- Address wrap: addr + k wraps modulo 2^32.

Optional Feature:
- ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; rr_ptr is removed.
- Undefined: round-robin as above.

Decomposition:
- Shared package/const.v: funct3 width codes, IO_SEL default, state encodings.
- Sub-module rr_picker: parametric N_CH find-first-from-pointer, returning a one-hot grant and index.

Test Plan:
- Reset, then ch1 lw 0x100 with memory bytes 11 22 33 44: mem_a 0x100..0x103, resp_valid[1] at grant+5, rdata 0x44332211.
- ch0 lb 0x10 = 0x80 → 0xFFFFFF80; lbu → 0x00000080; lh 0xFF7F → 0xFFFFFF7F.
- Both channels request continuously: grants alternate 0, 1, 0, 1. With ARB_FIXED_PRIO_EN, ch0 always wins.
- ch1 sb 0x30000 = 0x41 with io_buffer_full high 3 cycles: mem_wr stays 0 for those 3 cycles, then one write of 0x41; ack at grant+5.
- clear_all during ch0 lw second byte: no resp_valid[0], IDLE next cycle. clear_all during ch1 sw: all 4 bytes written, ack issued.
- rdy_in low mid-read for 2 cycles: mem_a frozen, latency +2, data correct. Reset mid-write: outputs 0 immediately.
